// File: rtl/bridge_scheduler_if.sv
// Handshake bundle between the bridge scheduler and the reader/writer buffers.
// The master modport is the scheduler side; the slave modport is the buffer side.
interface bridge_scheduler_if #(
    parameter int unsigned LEN_WIDTH = 4
) ();
    logic                 ar_pending;
    logic [LEN_WIDTH-1:0] ar_len;
    logic                 aw_pending;
    logic [LEN_WIDTH-1:0] aw_len;
    logic                 apb_done;
    logic                 apb_err;
    logic                 r_done;
    logic                 b_done;
    logic [1:0]           rd_cmd;
    logic [1:0]           wr_cmd;
    logic                 grant_rd;
    logic                 grant_wr;
    logic [1:0]           wr_resp;
    logic                 wr_resp_valid;
    logic                 busy;

    modport master (
        input  ar_pending, ar_len, aw_pending, aw_len,
        input  apb_done, apb_err, r_done, b_done,
        output rd_cmd, wr_cmd, grant_rd, grant_wr, wr_resp, wr_resp_valid, busy
    );

    modport slave (
        output ar_pending, ar_len, aw_pending, aw_len,
        output apb_done, apb_err, r_done, b_done,
        input  rd_cmd, wr_cmd, grant_rd, grant_wr, wr_resp, wr_resp_valid, busy
    );
endinterface

// File: rtl/bridge_scheduler.sv
// Central sequencer of the AXI-to-APB bridge: round-robin arbitration of the
// single APB port between read and write paths, beat counting and B response.
module bridge_scheduler #(
    parameter int unsigned LEN_WIDTH  = 4,
    parameter bit          RESET_PRIO = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    bridge_scheduler_if.master  bus
);

    localparam logic [1:0] R_DISABLE       = 2'd0;
    localparam logic [1:0] R_GET_ADDR_DATA = 2'd1;
    localparam logic [1:0] R_GET_RESP      = 2'd2;
    localparam logic [1:0] W_DISABLE       = 2'd0;
    localparam logic [1:0] W_GET_ADDR      = 2'd1;
    localparam logic [1:0] W_GET_DATA      = 2'd2;
    localparam logic [1:0] RESP_OKAY       = 2'b00;
    localparam logic [1:0] RESP_SLVERR     = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StRdXfer,
        StRdResp,
        StWrAddr,
        StWrXfer,
        StWrResp
    } state_e;

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                 err_q, err_d;
    // 1: the write path held the last grant, 0: the read path did.
    logic                 last_grant_q, last_grant_d;

    // State and burst bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            len_q        <= '0;
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
            last_grant_q <= !RESET_PRIO;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state: arbitration in idle, beat counting in the transfer states.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        beat_cnt_d   = beat_cnt_q;
        err_d        = err_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                if (bus.ar_pending && (!bus.aw_pending || last_grant_q)) begin
                    state_d      = StRdXfer;
                    len_d        = bus.ar_len;
                    beat_cnt_d   = '0;
                    err_d        = 1'b0;
                    last_grant_d = 1'b0;
                end else if (bus.aw_pending) begin
                    state_d      = StWrAddr;
                    len_d        = bus.aw_len;
                    beat_cnt_d   = '0;
                    err_d        = 1'b0;
                    last_grant_d = 1'b1;
                end
            end
            StRdXfer: begin
                if (bus.apb_done) begin
                    // Final beat holds the count at len_q so it never wraps.
                    if (beat_cnt_q == len_q) begin
                        state_d = StRdResp;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                    end
                end
            end
            StRdResp: begin
                if (bus.r_done) begin
                    state_d = StIdle;
                end
            end
            StWrAddr: begin
                state_d = StWrXfer;
            end
            StWrXfer: begin
                if (bus.apb_done) begin
                    err_d = err_q | bus.apb_err;
                    if (beat_cnt_q == len_q) begin
                        state_d = StWrResp;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                    end
                end
            end
            StWrResp: begin
                if (bus.b_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs decoded from registered state only.
    always_comb begin
        bus.rd_cmd        = R_DISABLE;
        bus.wr_cmd        = W_DISABLE;
        bus.grant_rd      = 1'b0;
        bus.grant_wr      = 1'b0;
        bus.wr_resp       = RESP_OKAY;
        bus.wr_resp_valid = 1'b0;
        bus.busy          = (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
            end
            StRdXfer: begin
                bus.rd_cmd   = R_GET_ADDR_DATA;
                bus.grant_rd = 1'b1;
            end
            StRdResp: begin
                bus.rd_cmd = R_GET_RESP;
            end
            StWrAddr: begin
                bus.wr_cmd = W_GET_ADDR;
            end
            StWrXfer: begin
                bus.wr_cmd   = W_GET_DATA;
                bus.grant_wr = 1'b1;
            end
            StWrResp: begin
                bus.wr_resp_valid = 1'b1;
                bus.wr_resp       = err_q ? RESP_SLVERR : RESP_OKAY;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/bridge_scheduler.md
# bridge_scheduler

Central sequencer for the AXI-to-APB bridge. It decides whether the single APB master port serves the read path or the write path, using a round-robin policy. It then drives the reader and writer bridge buffers through their command sequences, counts completed APB beats against the AXI burst length, and produces the aggregated write response for the B channel.

## Interface

Parameters:
- LEN_WIDTH, 4: width of the AXI burst length field (beats = len + 1).
- RESET_PRIO, 0: side preferred at the first arbitration after reset (0 = read, 1 = write).

Ports:
- clk  in  1  single bridge clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ar_pending  in  1  read buffer holds a complete AR request.
- ar_len  in  LEN_WIDTH  len of the pending AR request; valid while ar_pending.
- aw_pending  in  1  write buffer holds a complete AW request and its first W beat.
- aw_len  in  LEN_WIDTH  len of the pending AW request; valid while aw_pending.
- apb_done  in  1  one-cycle pulse: the current APB transfer completed (PREADY seen in ACCESS).
- apb_err  in  1  PSLVERR qualifier; sampled only with apb_done.
- r_done  in  1  pulse: read buffer has returned the last R beat to AXI.
- b_done  in  1  pulse: B handshake completed on AXI.
- rd_cmd  out  2  reader command; encoding R_DISABLE=0, R_GET_ADDR_DATA=1, R_GET_RESP=2.
- wr_cmd  out  2  writer command; encoding W_DISABLE=0, W_GET_ADDR=1, W_GET_DATA=2.
- grant_rd  out  1  APB port owned by the read path.
- grant_wr  out  1  APB port owned by the write path.
- wr_resp  out  2  aggregated write response: OKAY=2'b00, SLVERR=2'b10.
- wr_resp_valid  out  1  wr_resp is meaningful; asserted in WR_RESP.
- busy  out  1  state is not IDLE.

## Operation

State machine: IDLE, RD_XFER, RD_RESP, WR_ADDR, WR_XFER, WR_RESP.

- IDLE
  - If only ar_pending is high, go to RD_XFER. If only aw_pending is high, go to WR_ADDR.
  - If both are high, grant the side opposite to last_grant. Before the first grant, last_grant is treated as !RESET_PRIO.
  - On a grant: latch the len into len_q, clear beat_cnt, clear err_q, and update last_grant.
- RD_XFER
  - rd_cmd=1, grant_rd=1.
  - Each apb_done increments beat_cnt.
  - apb_done while beat_cnt==len_q moves to RD_RESP.
- RD_RESP
  - rd_cmd=2, grant_rd=0.
  - r_done moves to IDLE.
- WR_ADDR
  - wr_cmd=1 for exactly one cycle, then unconditionally WR_XFER.
- WR_XFER
  - wr_cmd=2, grant_wr=1.
  - apb_done increments beat_cnt; err_q |= apb_err.
  - apb_done while beat_cnt==len_q moves to WR_RESP.
- WR_RESP
  - wr_cmd=0, wr_resp_valid=1, wr_resp = err_q ? 2'b10 : 2'b00.
  - b_done moves to IDLE.
- All command and grant outputs are Moore outputs, decoded from the state register only. busy = (state != IDLE).
- apb_done outside RD_XFER/WR_XFER, r_done outside RD_RESP, and b_done outside WR_RESP are ignored and change no state.
- beat_cnt never exceeds len_q. It holds at its value on leaving the XFER state, so there is no wrap.
- Exactly one of grant_rd/grant_wr may be high at a time; both are never high together.

## Timing

- Reset values: state=IDLE, rd_cmd=0, wr_cmd=0, grant_rd=0, grant_wr=0, wr_resp=2'b00, wr_resp_valid=0, busy=0, beat_cnt=0, err_q=0, last_grant=!RESET_PRIO.
- Arbitration latency: pending sampled high in IDLE at edge N gives the command output at cycle N+1.
- Write start sequence: W_GET_ADDR lasts 1 cycle, and W_GET_DATA begins at N+2.
- Burst end: the final apb_done at edge M gives the RESP state command at cycle M+1.
- Return to IDLE: r_done/b_done at edge K gives busy=0 at K+1. The earliest re-arbitration is at edge K+1, so there is one IDLE cycle between bursts.
- A new request arriving mid-burst is held off until the current burst's RESP state completes.
- Asynchronous rst mid-burst forces all outputs to their reset values immediately. Partial beat counts and err_q are discarded.

## Test plan

- Single read, ar_len=0:
  - ar_pending → rd_cmd=1 at the next cycle.
  - One apb_done → rd_cmd=2.
  - r_done → IDLE, busy=0.
- Write burst, aw_len=3, err on beat 2:
  - Expect wr_cmd=1 for 1 cycle, then 2 for 4 apb_done pulses.
  - Then wr_resp=2'b10 with wr_resp_valid=1 until b_done.
- Both pending continuously from reset, RESET_PRIO=0, len=1 each:
  - Grant order is read, write, read, write.
  - grant_rd and grant_wr are never high simultaneously.
- Stray pulses:
  - apb_done in IDLE/RD_RESP and b_done during RD_XFER → no state change, beat_cnt unchanged.
- Max burst, aw_len=15:
  - Exactly 16 apb_done pulses are required before WR_RESP.
  - A 15th-pulse check confirms the state is still WR_XFER.
- Reset asserted in WR_XFER after 2 beats:
  - All outputs reset asynchronously.
  - After deassertion with ar_pending=1, the read is granted (last_grant reset to !RESET_PRIO).
